// File: rtl/queue_rd_stage.sv
// queue_rd_stage
//   Read side of the queue: issues pops into the pointer controller, captures
//   the SRAM read data RD_LAT cycles later into a small circular output
//   buffer, and presents the buffer head as a valid/ready stream. Pops are
//   credit-gated so every SRAM read already owns a buffer slot when issued.
//
// Ports
//   clk        clock
//   arst_n     active-low reset, sampled synchronously on rising clk
//   i_empty    upstream queue is empty
//   o_pop      pop request to the pointer controller (SRAM rd_en)
//   i_rd_data  SRAM read data, valid RD_LAT cycles after o_pop
//   o_valid    output word available
//   o_data     output word (buffer head)
//   i_ready    downstream accepts; transfer on o_valid & i_ready
//   o_busy     reads in flight or buffer non-empty
module queue_rd_stage #(
  parameter int W      = 32,
  parameter int RD_LAT = 1,
  parameter int BUF_N  = RD_LAT + 2
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_empty,
  output logic         o_pop,
  input  logic [W-1:0] i_rd_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic         o_busy
);

  localparam int PW = (BUF_N > 1) ? $clog2(BUF_N) : 1;
  localparam int CW = $clog2(BUF_N + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(BUF_N - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_N);

  logic [RD_LAT-1:0] r_inflight;
  // Pointers carry a wrap bit above the index: equal index with equal wrap
  // means empty, equal index with differing wrap means full.
  logic [PW:0]       r_wr_ptr;
  logic [PW:0]       r_rd_ptr;
  logic [CW-1:0]     r_occ;
  logic [W-1:0]      r_buf [BUF_N];

  logic [RD_LAT:0]   w_shift;
  logic [CW-1:0]     w_infl_cnt;
  logic [CW-1:0]     w_used;
  logic              w_land;
  logic              w_deq;
  logic              w_buf_empty;
  logic              w_buf_full;

  // Explicit wrap at BUF_N-1 so non-power-of-2 depths work.
  function automatic logic [PW:0] f_next(input logic [PW:0] p);
    if (p[PW-1:0] == LAST_IDX) begin
      return {~p[PW], {PW{1'b0}}};
    end
    return {p[PW], p[PW-1:0] + PW'(1)};
  endfunction

  assign w_shift = {r_inflight, o_pop};
  assign w_land  = r_inflight[RD_LAT-1];

  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_infl_cnt = w_infl_cnt + CW'(r_inflight[i]);
    end
  end

  // Credits: a slot is reserved from the pop until the word leaves the
  // buffer. A dequeue this cycle is only seen through r_occ next cycle, which
  // keeps i_ready out of the o_pop path.
  assign w_used  = r_occ + w_infl_cnt;
  assign o_pop   = ~i_empty & (w_used < FULL_CNT);

  assign o_valid = (r_occ != '0);
  assign w_deq   = o_valid & i_ready;
  assign o_data  = r_buf[r_rd_ptr[PW-1:0]];
  assign o_busy  = o_valid | (|r_inflight);

  assign w_buf_empty = (r_wr_ptr == r_rd_ptr);
  assign w_buf_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) &&
                       (r_wr_ptr[PW] != r_rd_ptr[PW]);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
    end else begin
      r_inflight <= w_shift[RD_LAT-1:0];
      if (w_land) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_deq) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_land, w_deq})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage has no reset; a landing during reset belongs to a discarded read.
  always_ff @(posedge clk) begin
    if (arst_n && w_land) begin
      r_buf[r_wr_ptr[PW-1:0]] <= i_rd_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
    r_occ <= FULL_CNT);
  a_pop_not_empty: assert property (@(posedge clk) disable iff (!arst_n)
    !(o_pop && i_empty));
  a_empty_flag: assert property (@(posedge clk) disable iff (!arst_n)
    (r_occ == '0) == w_buf_empty);
  a_full_flag: assert property (@(posedge clk) disable iff (!arst_n)
    (r_occ == FULL_CNT) == w_buf_full);
  a_stall_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data)));

endmodule

// File: tb/tb_queue_rd_stage.sv
module tb_queue_rd_stage;
  localparam int W      = 32;
  localparam int RD_LAT = 2;
  localparam int BUF_N  = 4;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         i_empty = 1'b1;
  logic         o_pop;
  logic [W-1:0] i_rd_data = '0;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         i_ready = 1'b0;
  logic         o_busy;

  always #5 clk = ~clk;

  queue_rd_stage #(.W(W), .RD_LAT(RD_LAT), .BUF_N(BUF_N)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_empty   (i_empty),
    .o_pop     (o_pop),
    .i_rd_data (i_rd_data),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (i_ready),
    .o_busy    (o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int t_at = 0;

  logic [W-1:0] src_q [$];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] pipe_d [RD_LAT];
  logic         pipe_v [RD_LAT] = '{default: 1'b0};
  logic         s_pop = 1'b0;
  logic         s_rst = 1'b1;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    src_q.push_back(d);
    exp_q.push_back(d);
  endtask

  // sel: 0 = o_pop high, 1 = o_valid high, 2 = o_busy low
  task automatic wait_for(input string tag, input int sel, input int max);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      @(negedge clk); #4;
      case (sel)
        0:       seen = o_pop;
        1:       seen = o_valid;
        default: seen = !o_busy;
      endcase
    end
    check(tag, 32'(seen), 1);
    t_at = cyc;
  endtask

  task automatic wait_drained(input string tag, input int max);
    for (int k = 0; k < max && exp_q.size() != 0; k++) @(posedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sample just before the active edge: what the DUT will act on at that edge.
  always @(negedge clk) begin
    #4;
    s_rst = !arst_n;
    s_pop = o_pop;
    if (arst_n) begin
      if (o_pop) check("pop_while_empty", 32'(i_empty), 0);
      if (prev_stall) begin
        check("stall_valid", 32'(o_valid), 1);
        check("stall_data", o_data, prev_data);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 32'(o_data), 32'hFFFF_FFFF);
        else check("sb_data", o_data, exp_q.pop_front());
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Upstream queue + SRAM model: pop removes the head, data appears RD_LAT later.
  always @(posedge clk) begin
    #1;
    if (s_rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = s_pop;
      pipe_d[0] = '0;
      if (s_pop) begin
        pop_cnt++;
        if (src_q.size() > 0) pipe_d[0] = src_q.pop_front();
        else check("src_underflow", 32'(src_q.size()), 1);
      end
    end
    i_rd_data = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : W'($urandom);
    i_empty   = (src_q.size() == 0);
  end

  initial begin
    int tp;
    int gaps;
    int n;

    // Reset state
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    check("rst_pop", 32'(o_pop), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_busy", 32'(o_busy), 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Single word: latency RD_LAT+1 from pop to valid
    @(negedge clk);
    i_ready = 1'b1;
    pop_cnt = 0;
    push(32'hA5A5_0001);
    wait_for("single_pop", 0, 20);
    tp = t_at;
    wait_for("single_valid", 1, 20);
    check("single_latency", t_at - tp, RD_LAT + 1);
    check("single_data", o_data, 32'hA5A5_0001);
    wait_drained("single_drain", 20);
    wait_for("single_idle", 2, 20);
    check("single_pops", pop_cnt, 1);

    // 64-word stream, no gaps after the fill
    @(negedge clk);
    pop_cnt = 0;
    for (int i = 0; i < 64; i++) push(32'h1000_0000 + 32'(i));
    wait_for("stream_pop", 0, 20);
    tp = t_at;
    wait_for("stream_valid", 1, 20);
    check("stream_fill", t_at - tp, RD_LAT + 1);
    gaps = 0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk); #4;
      if (!o_valid) gaps++;
    end
    check("stream_gaps", gaps, 0);
    wait_drained("stream_drain", 20);
    check("stream_pops", pop_cnt, 64);

    // Backpressure: buffer fills to BUF_N, pops stop, then drain 16 in order
    @(negedge clk);
    i_ready = 1'b0;
    pop_cnt = 0;
    for (int i = 0; i < 16; i++) push(32'h2000_0000 + 32'(i));
    repeat (20) @(negedge clk);
    #4;
    check("bp_pops", pop_cnt, BUF_N);
    check("bp_pop_low", 32'(o_pop), 0);
    check("bp_occ", 32'(dut.r_occ), BUF_N);
    check("bp_valid", 32'(o_valid), 1);
    check("bp_head", o_data, 32'h2000_0000);
    @(negedge clk);
    i_ready = 1'b1;
    wait_drained("bp_drain", 200);
    check("bp_total_pops", pop_cnt, 16);

    // i_ready toggling every cycle
    @(negedge clk);
    pop_cnt = 0;
    for (int i = 0; i < 20; i++) push(32'h3000_0000 + 32'(i * 7));
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      i_ready = ~i_ready;
    end
    check("toggle_drain", exp_q.size(), 0);
    i_ready = 1'b1;
    check("toggle_pops", pop_cnt, 20);

    // Queue runs dry after 5 words; o_busy drops one cycle after last transfer
    wait_for("pre_ms_idle", 2, 20);
    @(negedge clk);
    pop_cnt = 0;
    for (int i = 0; i < 5; i++) push(32'h4000_0000 + 32'(i));
    n = 0;
    for (int k = 0; k < 40 && n < 5; k++) begin
      @(negedge clk); #4;
      if (o_valid && i_ready) n++;
    end
    check("ms_count", n, 5);
    check("ms_busy_last", 32'(o_busy), 1);
    @(negedge clk); #4;
    check("ms_busy_after", 32'(o_busy), 0);
    check("ms_valid_after", 32'(o_valid), 0);
    check("ms_pop_after", 32'(o_pop), 0);
    check("ms_pops", pop_cnt, 5);

    // Reset with two reads in flight
    @(negedge clk);
    pop_cnt = 0;
    for (int i = 0; i < 10; i++) push(32'hBAD0_0000 + 32'(i));
    for (int k = 0; k < 20 && pop_cnt < 2; k++) @(negedge clk);
    check("mrst_pops", pop_cnt, 2);
    arst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    #4;
    check("mrst_inflight", 32'($countones(dut.r_inflight)), 2);
    @(negedge clk); #4;
    check("mrst_valid", 32'(o_valid), 0);
    check("mrst_busy", 32'(o_busy), 0);
    @(negedge clk);
    arst_n = 1'b1;
    pop_cnt = 0;
    for (int i = 0; i < 3; i++) push(32'hC0DE_0000 + 32'(i));
    wait_drained("post_rst_drain", 40);
    wait_for("post_rst_idle", 2, 20);
    check("post_rst_pops", pop_cnt, 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
